// File: rtl/phase_comps_sched_if.sv
// Sample-stream framing and coefficient-config bus for phase_comps_sched.
// master = stream source / host; slave = the scheduler.
interface phase_comps_sched_if;
  logic        din_valid;
  logic        din_sop;
  logic        din_eop;
  logic        frame_sync;
  logic        cfg_wr_en;
  logic [4:0]  cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_commit;
  logic        cfg_busy;

  modport master (
    output din_valid, din_sop, din_eop, frame_sync,
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
    input  cfg_busy
  );

  modport slave (
    input  din_valid, din_sop, din_eop, frame_sync,
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
    output cfg_busy
  );
endinterface

// File: rtl/phase_comps_sched.sv
// Symbol/slot sequencer with double-buffered phase-compensation coefficients.
// Define PHASE_COMPS_SCHED_ERR_CNT_EN to add the saturating err_cnt output.
module phase_comps_sched #(
  parameter int unsigned COEF_NUM       = 28,
  parameter int unsigned SYM_PER_SLOT   = 14,
  parameter int unsigned SLOT_PER_FRAME = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  phase_comps_sched_if.slave  bus,
  output logic [3:0]          sym_index,
  output logic [7:0]          slot_index,
  output logic [31:0]         coef_data [COEF_NUM],
  output logic                err_seq,
  output logic                err_wr_drop
`ifdef PHASE_COMPS_SCHED_ERR_CNT_EN
  ,
  output logic [15:0]         err_cnt
`endif
);

  localparam logic [3:0]  LAST_SYM  = 4'(SYM_PER_SLOT - 1);
  localparam logic [7:0]  LAST_SLOT = 8'(SLOT_PER_FRAME - 1);
  localparam logic [31:0] COEF_UNITY = 32'h0000_7FFF;

  typedef enum logic {S_IDLE, S_IN_SYM} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sym_q, sym_d;
  logic [7:0]  slot_q, slot_d;
  logic        busy_q, busy_d;
  logic        err_seq_q, err_wr_drop_q;
  logic [31:0] shadow_q [COEF_NUM];
  logic [31:0] active_q [COEF_NUM];

  logic sop, eop, adv, seq_err;
  logic boundary, copy, wr_ok, wr_drop;

  assign sop = bus.din_valid & bus.din_sop;
  assign eop = bus.din_valid & bus.din_eop;

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    seq_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sop && eop) begin
          adv = 1'b1;
        end else if (sop) begin
          state_d = S_IN_SYM;
        end else if (eop) begin
          seq_err = 1'b1;
        end
      end
      S_IN_SYM: begin
        // A stray sop closes the open symbol; with eop it is also the last sample.
        if (sop) begin
          seq_err = 1'b1;
          adv     = 1'b1;
          state_d = eop ? S_IDLE : S_IN_SYM;
        end else if (eop) begin
          adv     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign boundary = adv && (sym_q == LAST_SYM);

  always_comb begin
    sym_d  = sym_q;
    slot_d = slot_q;
    if (bus.frame_sync) begin
      sym_d  = '0;
      slot_d = '0;
    end else if (adv) begin
      if (sym_q == LAST_SYM) begin
        sym_d  = '0;
        slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 8'd1;
      end else begin
        sym_d = sym_q + 4'd1;
      end
    end
  end

  // Only a request already latched in busy_q can commit, so a commit that
  // coincides with a boundary waits for the following one.
  assign copy = busy_q &&
                (boundary || bus.frame_sync || (state_q == S_IDLE && sym_q == '0));
  assign wr_ok   = bus.cfg_wr_en && !busy_q && (32'(bus.cfg_wr_addr) < COEF_NUM);
  assign wr_drop = bus.cfg_wr_en && busy_q;

  always_comb begin
    busy_d = busy_q;
    if (copy) begin
      busy_d = 1'b0;
    end else if (bus.cfg_commit) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sym_q         <= '0;
      slot_q        <= '0;
      busy_q        <= 1'b0;
      err_seq_q     <= 1'b0;
      err_wr_drop_q <= 1'b0;
      for (int unsigned i = 0; i < COEF_NUM; i++) begin
        shadow_q[i] <= COEF_UNITY;
        active_q[i] <= COEF_UNITY;
      end
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
      if (seq_err) err_seq_q     <= 1'b1;
      if (wr_drop) err_wr_drop_q <= 1'b1;
      if (wr_ok)   shadow_q[bus.cfg_wr_addr] <= bus.cfg_wr_data;
      if (copy)    active_q <= shadow_q;
    end
  end

`ifdef PHASE_COMPS_SCHED_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_cnt_q} + 17'(seq_err) + 17'(wr_drop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign bus.cfg_busy = busy_q;
  assign sym_index    = sym_q;
  assign slot_index   = slot_q;
  assign coef_data    = active_q;
  assign err_seq      = err_seq_q;
  assign err_wr_drop  = err_wr_drop_q;

endmodule

// File: tb/tb_phase_comps_sched.sv
// Directed bench for phase_comps_sched: framing, slot wrap, commit timing,
// write drop, framing errors, frame_sync and reset-mid-commit.
module tb_phase_comps_sched;
  localparam int unsigned COEF_NUM = 28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sym_index;
  logic [7:0]  slot_index;
  logic [31:0] coef_data [COEF_NUM];
  logic        err_seq;
  logic        err_wr_drop;
`ifdef PHASE_COMPS_SCHED_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  phase_comps_sched_if bus_if ();

  phase_comps_sched #(
    .COEF_NUM       (28),
    .SYM_PER_SLOT   (14),
    .SLOT_PER_FRAME (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.slave),
    .sym_index   (sym_index),
    .slot_index  (slot_index),
    .coef_data   (coef_data),
    .err_seq     (err_seq),
    .err_wr_drop (err_wr_drop)
`ifdef PHASE_COMPS_SCHED_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic sop, input logic eop);
    bus_if.din_valid = 1'b1;
    bus_if.din_sop   = sop;
    bus_if.din_eop   = eop;
    tick();
    bus_if.din_valid = 1'b0;
    bus_if.din_sop   = 1'b0;
    bus_if.din_eop   = 1'b0;
  endtask

  task automatic send_symbol();
    for (int i = 0; i < 4; i++) drive_sample(i == 0, i == 3);
  endtask

  task automatic host_write(input logic [4:0] addr, input logic [31:0] data);
    bus_if.cfg_wr_en   = 1'b1;
    bus_if.cfg_wr_addr = addr;
    bus_if.cfg_wr_data = data;
    tick();
    bus_if.cfg_wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned exp_sym;
    int unsigned exp_slot;
    int unsigned n_bad;

    rst_n              = 1'b0;
    bus_if.din_valid   = 1'b0;
    bus_if.din_sop     = 1'b0;
    bus_if.din_eop     = 1'b0;
    bus_if.frame_sync  = 1'b0;
    bus_if.cfg_wr_en   = 1'b0;
    bus_if.cfg_wr_addr = '0;
    bus_if.cfg_wr_data = '0;
    bus_if.cfg_commit  = 1'b0;
    tick();
    do_reset();

    check("rst_sym", 32'(sym_index), 0);
    check("rst_slot", 32'(slot_index), 0);
    check("rst_busy", 32'(bus_if.cfg_busy), 0);
    check("rst_err_seq", 32'(err_seq), 0);
    check("rst_err_drop", 32'(err_wr_drop), 0);
    check("rst_coef0", coef_data[0], 32'h0000_7FFF);
    check("rst_coef27", coef_data[27], 32'h0000_7FFF);

    // First slot checked symbol-by-symbol, then run to the frame wrap.
    for (int s = 0; s < 14; s++) begin
      send_symbol();
      check("slot0_sym", 32'(sym_index), (s == 13) ? 0 : s + 1);
      check("slot0_slot", 32'(slot_index), (s == 13) ? 1 : 0);
    end
    exp_sym  = 0;
    exp_slot = 1;
    n_bad    = 0;
    for (int s = 14; s < 280; s++) begin
      send_symbol();
      if (exp_sym == 13) begin
        exp_sym  = 0;
        exp_slot = (exp_slot == 19) ? 0 : exp_slot + 1;
      end else begin
        exp_sym++;
      end
      if (32'(sym_index) != exp_sym || 32'(slot_index) != exp_slot) n_bad++;
      if (s == 278) begin
        check("pre_wrap_sym", 32'(sym_index), 13);
        check("pre_wrap_slot", 32'(slot_index), 19);
      end
    end
    check("frame_walk_mismatches", n_bad, 0);
    check("wrap_sym", 32'(sym_index), 0);
    check("wrap_slot", 32'(slot_index), 0);

    // Commit requested mid-symbol 5 must wait for the slot boundary.
    host_write(5'd3, 32'h1234_5678);
    host_write(5'd30, 32'hFFFF_FFFF);
    for (int s = 0; s < 5; s++) send_symbol();
    check("sym5_start", 32'(sym_index), 5);
    drive_sample(1'b1, 1'b0);
    bus_if.cfg_commit = 1'b1;
    drive_sample(1'b0, 1'b0);
    bus_if.cfg_commit = 1'b0;
    check("busy_after_commit", 32'(bus_if.cfg_busy), 1);
    bus_if.cfg_wr_en   = 1'b1;
    bus_if.cfg_wr_addr = 5'd0;
    bus_if.cfg_wr_data = 32'hDEAD_BEEF;
    drive_sample(1'b0, 1'b0);
    bus_if.cfg_wr_en   = 1'b0;
    check("err_wr_drop_set", 32'(err_wr_drop), 1);
    drive_sample(1'b0, 1'b1);
    check("coef3_held_sym6", coef_data[3], 32'h0000_7FFF);
    for (int s = 6; s < 13; s++) send_symbol();
    check("coef3_held_sym13", coef_data[3], 32'h0000_7FFF);
    check("busy_held_sym13", 32'(bus_if.cfg_busy), 1);
    for (int i = 0; i < 3; i++) drive_sample(i == 0, 1'b0);
    check("coef3_held_pre_eop", coef_data[3], 32'h0000_7FFF);
    drive_sample(1'b0, 1'b1);
    check("coef3_committed", coef_data[3], 32'h1234_5678);
    check("busy_cleared", 32'(bus_if.cfg_busy), 0);
    check("coef0_not_dropped_write", coef_data[0], 32'h0000_7FFF);
    check("slot1_after_commit", 32'(slot_index), 1);
    check("err_wr_drop_sticky", 32'(err_wr_drop), 1);
`ifdef PHASE_COMPS_SCHED_ERR_CNT_EN
    check("err_cnt_drop", 32'(err_cnt), 1);
`endif

    // Double sop starting at symbol 2, then a stray eop while idle.
    send_symbol();
    send_symbol();
    check("err_seq_clear", 32'(err_seq), 0);
    drive_sample(1'b1, 1'b0);
    drive_sample(1'b0, 1'b0);
    drive_sample(1'b0, 1'b0);
    drive_sample(1'b1, 1'b0);
    check("double_sop_err", 32'(err_seq), 1);
    check("double_sop_implicit_adv", 32'(sym_index), 3);
    drive_sample(1'b0, 1'b1);
    check("double_sop_eop_sym", 32'(sym_index), 4);
    drive_sample(1'b0, 1'b1);
    check("idle_eop_no_adv", 32'(sym_index), 4);
    check("err_seq_sticky", 32'(err_seq), 1);
`ifdef PHASE_COMPS_SCHED_ERR_CNT_EN
    check("err_cnt_seq", 32'(err_cnt), 3);
`endif

    // Walk to slot 3, symbol 7, then frame_sync with a commit pending.
    for (int s = 0; s < 10 + 14 + 7; s++) send_symbol();
    check("pre_fs_sym", 32'(sym_index), 7);
    check("pre_fs_slot", 32'(slot_index), 3);
    host_write(5'd5, 32'hA5A5_5A5A);
    bus_if.cfg_commit = 1'b1;
    tick();
    bus_if.cfg_commit = 1'b0;
    check("fs_busy_pending", 32'(bus_if.cfg_busy), 1);
    drive_sample(1'b1, 1'b0);
    bus_if.frame_sync = 1'b1;
    drive_sample(1'b0, 1'b0);
    bus_if.frame_sync = 1'b0;
    check("fs_sym", 32'(sym_index), 0);
    check("fs_slot", 32'(slot_index), 0);
    check("fs_busy_clear", 32'(bus_if.cfg_busy), 0);
    check("fs_coef5", coef_data[5], 32'h A5A5_5A5A);
    drive_sample(1'b0, 1'b1);
    check("fs_state_kept_adv", 32'(sym_index), 1);

    // Reset mid-symbol with a commit pending discards everything.
    host_write(5'd7, 32'h1111_2222);
    bus_if.cfg_commit = 1'b1;
    tick();
    bus_if.cfg_commit = 1'b0;
    check("rst2_busy_pending", 32'(bus_if.cfg_busy), 1);
    drive_sample(1'b1, 1'b0);
    do_reset();
    check("rst2_sym", 32'(sym_index), 0);
    check("rst2_slot", 32'(slot_index), 0);
    check("rst2_busy", 32'(bus_if.cfg_busy), 0);
    check("rst2_err_seq", 32'(err_seq), 0);
    check("rst2_err_drop", 32'(err_wr_drop), 0);
    check("rst2_coef3", coef_data[3], 32'h0000_7FFF);
    check("rst2_coef5", coef_data[5], 32'h0000_7FFF);
    check("rst2_coef7", coef_data[7], 32'h0000_7FFF);
`ifdef PHASE_COMPS_SCHED_ERR_CNT_EN
    check("rst2_err_cnt", 32'(err_cnt), 0);
`endif

    // Idle at symbol 0: a commit lands the cycle after busy rises.
    host_write(5'd9, 32'hCAFE_0001);
    bus_if.cfg_commit = 1'b1;
    tick();
    bus_if.cfg_commit = 1'b0;
    check("idle_commit_busy", 32'(bus_if.cfg_busy), 1);
    check("idle_commit_not_yet", coef_data[9], 32'h0000_7FFF);
    tick();
    check("idle_commit_coef9", coef_data[9], 32'hCAFE_0001);
    check("idle_commit_busy_clear", 32'(bus_if.cfg_busy), 0);
    check("idle_commit_coef7_discarded", coef_data[7], 32'h0000_7FFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
